elemwise_stream_seq: RTL and testbench
======================================

Name: elemwise_stream_seq

Overview:
- Parametrised successor to the block-at-a-time elementwise FSM.
- Streams BANDWIDTH-lane words of A, and B or scalar, through an external fixed-latency FP unit, one word per cycle, with read, compute and write fully overlapped.
- Handles any word count, not only multiples of SINGLE_ACCESS.
- Sits between the op decoder (start, op_code, scalar, n_words) and the A/B/Res memory ports.

Parameters:
- DATA_WIDTH, 32, bits per lane
- BANDWIDTH, 8, lanes per memory word
- ADDR_WIDTH, 11, memory word address width
- A_BASE, 0, word base of A
- B_BASE, 0, word base of B
- RES_BASE, 0, word base of result
- LAT_ADD, 7, FU latency for add-class ops in cycles
- LAT_MUL, 5, FU latency for mul-class ops in cycles
- LAT_DIV, 6, FU latency for div-class ops in cycles

Ports:
- clock  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  one-cycle request, sampled only in IDLE
- op_code  in  4  op_code_t
- scalar  in  DATA_WIDTH  scalar operand, captured at start
- n_words  in  ADDR_WIDTH  number of words to process, captured at start
- memA_read / memB_read  out  1  read strobes
- memA_addr / memB_addr  out  ADDR_WIDTH  read addresses
- readdataA / readdataB  in  BANDWIDTH*DATA_WIDTH  read data, valid 1 cycle after strobe
- fu_valid  out  1  operands valid this cycle
- fu_class  out  2  0=add, 1=mul, 2=div
- fu_a / fu_b  out  BANDWIDTH*DATA_WIDTH  operands
- fu_result  in  BANDWIDTH*DATA_WIDTH  result, valid exactly LAT cycles after fu_valid
- memRes_write  out  1  write strobe
- memRes_addr  out  ADDR_WIDTH  write address
- memRes_writedata  out  BANDWIDTH*DATA_WIDTH  write data, equal to fu_result
- busy  out  1  high in RUN, DRAIN and FIN
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for an unsupported op

Behaviour:
- Reset: state IDLE; counters and captured registers are 0; every output is 0. Reset mid-operation aborts immediately with no further strobes.
- States are IDLE, RUN, DRAIN, FIN.
- IDLE, start and op valid, n_words>0: capture op, scalar and n_words; clear rd_ptr and wr_ptr; go to RUN.
- IDLE, start and op unsupported, or n_words=0: go to FIN with no memory access. err is latched for the unsupported-op case.
- Supported ops and classes:
  - MAT_ADD: add, fu_b=B
  - MAT_SCAL_ADD: add, fu_b=scalar
  - MAT_SCAL_MUL: mul, fu_b=scalar
  - MAT_SCAL_DIV: div, fu_b=scalar
- Scalar is replicated to all lanes. memB_read is asserted only for MAT_ADD.
- LAT is selected by class from the captured op and is constant for the whole op.
- RUN, cycle k (k=0..n-1): memA_read=1 with memA_addr=A_BASE+k, B likewise; rd_ptr increments. After read n-1, go to DRAIN.
- fu_valid is the read strobe delayed 1 cycle. fu_a and fu_b are driven combinationally from readdata at that time.
- Write timing: a valid-delay shift register of depth max(LAT)+1, tapped at LAT. When the tap is high: memRes_write=1, memRes_addr=RES_BASE+wr_ptr, wr_ptr increments.
- DRAIN: when the write of word n-1 has been issued, go to FIN.
- FIN: done=1 for one cycle, err as latched, then IDLE.
- Timing: first write occurs LAT+2 cycles after the start edge. done occurs n+LAT+2 cycles after the start edge. Throughput is 1 word per cycle, with no bubbles.
- Addresses wrap modulo 2^ADDR_WIDTH.
- start while busy is ignored. Input changes while busy are ignored.
- No backpressure: memories and FU accept every strobe.

Decomposition:
- Shared package: op_code_t (MAT_ADD, MAT_SCAL_MUL, MAT_SCAL_DIV, MAT_SCAL_ADD, MAT_SCAL_INV, MAT_MUL), fu_class_t, DATA_WIDTH, BANDWIDTH, ADDR_WIDTH.
- One sub-module: valid_delay_line, a parametrised depth shift register with a run-time tap select. Reuse the existing Counter and Register.

Test Plan:
- MAT_ADD, n=3, A={1.0,2.0,3.0}, B={2.0}×3 (fp32 0x3F800000…) with a 7-cycle model FU -> Res words 0x40400000, 0x40800000, 0x40A00000 at RES_BASE+0..2; writes on consecutive cycles; done at cycle 12 after start.
- MAT_SCAL_MUL, n=5, scalar=2.0 -> memB_read never asserted; Res[k]=2·A[k]; first write 7 cycles after start (LAT_MUL=5).
- n_words=0 and op MAT_MUL -> no strobes. done pulses 2 cycles after start; err=1 only for MAT_MUL.
- start re-pulsed mid-RUN with a different op -> ignored; the original op completes with its own results.
- Reset asserted in DRAIN -> all outputs 0 same cycle; a new op after release runs normally.
- A_BASE=2046, n=4 -> read addresses 2046, 2047, 0, 1 (wrap).

Source files
------------

// File: rtl/elemwise_stream_seq_pkg.sv
// rtl/elemwise_stream_seq_pkg.sv - shared op codes, FU classes and default widths
// for the streaming elementwise sequencer.
package elemwise_stream_seq_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BANDWIDTH  = 8;
  localparam int ADDR_WIDTH = 11;

  typedef enum logic [3:0] {
    MAT_ADD      = 4'd0,
    MAT_SCAL_MUL = 4'd1,
    MAT_SCAL_DIV = 4'd2,
    MAT_SCAL_ADD = 4'd3,
    MAT_SCAL_INV = 4'd4,
    MAT_MUL      = 4'd5
  } op_code_t;

  typedef enum logic [1:0] {
    FU_ADD = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2
  } fu_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      MAT_ADD, MAT_SCAL_ADD, MAT_SCAL_MUL, MAT_SCAL_DIV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic fu_class_t op_class(input logic [3:0] op);
    case (op)
      MAT_SCAL_MUL: return FU_MUL;
      MAT_SCAL_DIV: return FU_DIV;
      default:      return FU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/elemwise_stream_seq_valid_delay_line.sv
// rtl/elemwise_stream_seq_valid_delay_line.sv - valid shift register with a
// run-time tap; tap i gives the input delayed by i+1 cycles.
module valid_delay_line #(
  parameter int DEPTH = 8,
  parameter int TAP_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [TAP_W-1:0] tap,
  output logic             tapped
);

  logic [DEPTH-1:0] line;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line <= '0;
    end else begin
      line <= {line[DEPTH-2:0], valid};
    end
  end

  assign tapped = line[tap];

endmodule

// File: rtl/elemwise_stream_seq.sv
// rtl/elemwise_stream_seq.sv - streams A (and B or a replicated scalar) through a
// fixed-latency FP unit with read, compute and write overlapped, one word per cycle.
module elemwise_stream_seq
  import elemwise_stream_seq_pkg::*;
#(
  parameter int DATA_WIDTH = elemwise_stream_seq_pkg::DATA_WIDTH,
  parameter int BANDWIDTH  = elemwise_stream_seq_pkg::BANDWIDTH,
  parameter int ADDR_WIDTH = elemwise_stream_seq_pkg::ADDR_WIDTH,
  parameter int A_BASE     = 0,
  parameter int B_BASE     = 0,
  parameter int RES_BASE   = 0,
  parameter int LAT_ADD    = 7,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 6
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [3:0]                        op_code,
  input  logic [DATA_WIDTH-1:0]             scalar,
  input  logic [ADDR_WIDTH-1:0]             n_words,
  output logic                              memA_read,
  output logic                              memB_read,
  output logic [ADDR_WIDTH-1:0]             memA_addr,
  output logic [ADDR_WIDTH-1:0]             memB_addr,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0]   readdataA,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0]   readdataB,
  output logic                              fu_valid,
  output logic [1:0]                        fu_class,
  output logic [BANDWIDTH*DATA_WIDTH-1:0]   fu_a,
  output logic [BANDWIDTH*DATA_WIDTH-1:0]   fu_b,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0]   fu_result,
  output logic                              memRes_write,
  output logic [ADDR_WIDTH-1:0]             memRes_addr,
  output logic [BANDWIDTH*DATA_WIDTH-1:0]   memRes_writedata,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int LAT_MAX = (LAT_ADD > LAT_MUL) ? ((LAT_ADD > LAT_DIV) ? LAT_ADD : LAT_DIV)
                                               : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
  localparam int DEPTH   = LAT_MAX + 1;
  localparam int TAP_W   = $clog2(DEPTH);

  state_t                  state, state_nx;
  logic [3:0]              op_q;
  logic [DATA_WIDTH-1:0]   scalar_q;
  logic [ADDR_WIDTH-1:0]   n_q, rd_ptr, wr_ptr;
  logic                    err_q, rd_valid, tap_hit, use_b, accept;
  logic [TAP_W-1:0]        lat_sel;

  assign use_b  = (op_q == MAT_ADD);
  assign accept = op_supported(op_code) && (n_words != '0);

  always_comb begin
    case (op_class(op_q))
      FU_MUL:  lat_sel = TAP_W'(LAT_MUL);
      FU_DIV:  lat_sel = TAP_W'(LAT_DIV);
      default: lat_sel = TAP_W'(LAT_ADD);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      scalar_q <= '0;
      n_q      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= memA_read;
      if (state == S_IDLE && start) begin
        op_q     <= op_code;
        scalar_q <= scalar;
        n_q      <= n_words;
        err_q    <= ~op_supported(op_code);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (memA_read) rd_ptr <= rd_ptr + 1'b1;
        if (tap_hit)   wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    memA_read = 1'b0;
    memB_read = 1'b0;
    memA_addr = '0;
    memB_addr = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = accept ? S_RUN : S_FIN;
      end
      S_RUN: begin
        busy      = 1'b1;
        memA_read = 1'b1;
        memB_read = use_b;
        memA_addr = ADDR_WIDTH'(A_BASE) + rd_ptr;
        memB_addr = use_b ? ADDR_WIDTH'(B_BASE) + rd_ptr : '0;
        if (rd_ptr == n_q - 1'b1) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tap_hit && wr_ptr == n_q - 1'b1) state_nx = S_FIN;
      end
      default: begin
        busy     = 1'b1;
        done     = 1'b1;
        err      = err_q;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Read strobe delayed by LAT+1 marks the cycle the FU result for that word appears.
  valid_delay_line #(
    .DEPTH(DEPTH),
    .TAP_W(TAP_W)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .valid (memA_read),
    .tap   (lat_sel),
    .tapped(tap_hit)
  );

  assign fu_valid         = rd_valid;
  assign fu_class         = op_class(op_q);
  assign fu_a             = rd_valid ? readdataA : '0;
  assign fu_b             = !rd_valid ? '0 : (use_b ? readdataB : {BANDWIDTH{scalar_q}});
  assign memRes_write     = tap_hit;
  assign memRes_addr      = tap_hit ? ADDR_WIDTH'(RES_BASE) + wr_ptr : '0;
  assign memRes_writedata = tap_hit ? fu_result : '0;

endmodule

// File: tb/tb_elemwise_stream_seq.sv
// tb/tb_elemwise_stream_seq.sv - randomized self-checking bench with memory and
// FP-unit models and a word-level reference for the streaming sequencer.
module tb_elemwise_stream_seq;
  import elemwise_stream_seq_pkg::*;

  localparam int DW  = 32;
  localparam int BW  = 8;
  localparam int AW  = 11;
  localparam int WW  = BW * DW;
  localparam int A_B = 2046;
  localparam int B_B = 2047;
  localparam int R_B = 2045;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] op_code = '0;
  logic [DW-1:0] scalar = '0;
  logic [AW-1:0] n_words = '0;
  logic memA_read, memB_read, fu_valid, memRes_write, busy, done, err;
  logic [AW-1:0] memA_addr, memB_addr, memRes_addr;
  logic [1:0] fu_class;
  logic [WW-1:0] readdataA = '0, readdataB = '0;
  logic [WW-1:0] fu_a, fu_b, fu_result, memRes_writedata;

  elemwise_stream_seq #(
    .A_BASE(A_B), .B_BASE(B_B), .RES_BASE(R_B),
    .LAT_ADD(7), .LAT_MUL(5), .LAT_DIV(6)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .op_code(op_code),
    .scalar(scalar), .n_words(n_words),
    .memA_read(memA_read), .memB_read(memB_read),
    .memA_addr(memA_addr), .memB_addr(memB_addr),
    .readdataA(readdataA), .readdataB(readdataB),
    .fu_valid(fu_valid), .fu_class(fu_class), .fu_a(fu_a), .fu_b(fu_b),
    .fu_result(fu_result), .memRes_write(memRes_write), .memRes_addr(memRes_addr),
    .memRes_writedata(memRes_writedata), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  logic [WW-1:0] mem_a [0:2047];
  logic [WW-1:0] mem_b [0:2047];
  logic [WW-1:0] mem_r [0:2047];
  logic [WW-1:0] pipe  [0:7];
  logic [WW-1:0] stage_in = '0, rd_a_nx = '0, rd_b_nx = '0;
  int cyc = 0, fu_lat = 7;
  int n_wr, n_brd, n_done, err_seen, first_wr, done_cyc;
  int a_log[$], b_log[$], w_log[$];
  int errors = 0, checks = 0;
  logic [31:0] lit [0:2] = '{32'h40400000, 32'h40800000, 32'h40A00000};

  function automatic real fp2r(input logic [31:0] f);
    real m;
    int e;
    if (f[30:0] == 31'd0) return 0.0;
    e = int'(f[30:23]) - 127;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] b;
    int e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // kind: 0 add, 1 multiply, 2 divide, applied lane by lane
  function automatic logic [WW-1:0] lanes(input int kind, input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [WW-1:0] r;
    real x, y;
    r = '0;
    for (int i = 0; i < BW; i++) begin
      x = fp2r(a[i*DW +: DW]);
      y = fp2r(b[i*DW +: DW]);
      r[i*DW +: DW] = (kind == 1) ? r2fp(x * y) : (kind == 2) ? r2fp(x / y) : r2fp(x + y);
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < BW; i++) w[i*DW +: DW] = r2fp(real'($urandom_range(1, 1000)));
    return w;
  endfunction

  assign fu_result = pipe[fu_lat - 1];

  always @(posedge clock) begin
    cyc = cyc + 1;
    readdataA = rd_a_nx;
    readdataB = rd_b_nx;
    for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = stage_in;
  end

  always @(negedge clock) begin
    rd_a_nx  = memA_read ? mem_a[memA_addr] : '0;
    rd_b_nx  = memB_read ? mem_b[memB_addr] : '0;
    stage_in = fu_valid ? lanes(int'(fu_class), fu_a, fu_b) : '0;
    if (memA_read) a_log.push_back(int'(memA_addr));
    if (memB_read) begin
      b_log.push_back(int'(memB_addr));
      n_brd++;
    end
    if (memRes_write) begin
      mem_r[memRes_addr] = memRes_writedata;
      w_log.push_back(int'(memRes_addr));
      if (n_wr == 0) first_wr = cyc;
      n_wr++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      err_seen = int'(err);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    n_wr = 0; n_brd = 0; n_done = 0; err_seen = 0; first_wr = -1; done_cyc = -1;
    a_log.delete(); b_log.delete(); w_log.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, {memA_read, memB_read, memA_addr, memB_addr, fu_valid, fu_class,
                           memRes_write, memRes_addr, busy, done, err}, '0);
    check({tag, "_fu_a"}, fu_a, '0);
    check({tag, "_fu_b"}, fu_b, '0);
    check({tag, "_wdata"}, memRes_writedata, '0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] sc, input int n,
                        input bit fill, input bit repulse);
    logic [WW-1:0] exp_w [$];
    bit sup;
    int kind, lat, s, ai, bi, ri;
    sup  = (op == MAT_ADD) || (op == MAT_SCAL_ADD) || (op == MAT_SCAL_MUL) || (op == MAT_SCAL_DIV);
    kind = (op == MAT_SCAL_MUL) ? 1 : (op == MAT_SCAL_DIV) ? 2 : 0;
    lat  = (kind == 1) ? 5 : (kind == 2) ? 6 : 7;
    fu_lat = lat;
    for (int k = 0; k < n; k++) begin
      ai = (A_B + k) % 2048; bi = (B_B + k) % 2048; ri = (R_B + k) % 2048;
      if (fill) begin
        mem_a[ai] = rand_word();
        mem_b[bi] = rand_word();
      end
      mem_r[ri] = '1;
      exp_w.push_back(lanes(kind, mem_a[ai], (op == MAT_ADD) ? mem_b[bi] : {BW{sc}}));
    end
    clear_logs();
    tick();
    op_code = op; scalar = sc; n_words = AW'(n); start = 1'b1;
    tick();
    start = 1'b0; s = cyc;
    op_code = 4'($urandom_range(0, 15)); scalar = $urandom; n_words = AW'($urandom);
    if (repulse) begin
      tick(); tick();
      op_code = MAT_ADD; scalar = 32'h3F800000; n_words = AW'(1); start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int t = 0; t < 300 && n_done == 0; t++) tick();
    repeat (3) tick();
    check("done_count", n_done, 1);
    check("err_flag", err_seen, sup ? 0 : 1);
    check("write_count", n_wr, sup ? n : 0);
    check("b_read_count", n_brd, (sup && op == MAT_ADD) ? n : 0);
    check("a_read_count", a_log.size(), sup ? n : 0);
    if (sup && n > 0) begin
      check("first_write_latency", first_wr + 1 - s, lat + 2);
      check("done_latency", done_cyc + 1 - s, n + lat + 2);
      for (int k = 0; k < n; k++) begin
        ai = (A_B + k) % 2048; bi = (B_B + k) % 2048; ri = (R_B + k) % 2048;
        check("a_addr", (k < a_log.size()) ? a_log[k] : -1, ai);
        if (op == MAT_ADD) check("b_addr", (k < b_log.size()) ? b_log[k] : -1, bi);
        check("res_addr", (k < w_log.size()) ? w_log[k] : -1, ri);
        check("res_data", mem_r[ri], exp_w[k]);
      end
    end else begin
      check("quick_done", (done_cyc >= 0) && (done_cyc + 1 - s <= 2), 1);
    end
  endtask

  logic [31:0] pow2_sc [0:2] = '{32'h3F000000, 32'h40000000, 32'h40800000};
  logic [3:0]  sup_ops [0:3] = '{MAT_ADD, MAT_SCAL_ADD, MAT_SCAL_MUL, MAT_SCAL_DIV};

  initial begin
    logic [3:0] op;
    logic [31:0] sc;
    int s;
    for (int i = 0; i < 8; i++) pipe[i] = '0;
    clear_logs();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < BW; i++) begin
        mem_a[(A_B + k) % 2048][i*DW +: DW] = r2fp(real'(k + 1));
        mem_b[(B_B + k) % 2048][i*DW +: DW] = 32'h40000000;
      end
    run_op(MAT_ADD, 32'h0, 3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) check("add_literal", mem_r[(R_B + k) % 2048][31:0], lit[k]);

    run_op(MAT_SCAL_MUL, 32'h40000000, 5, 1'b1, 1'b0);
    run_op(MAT_ADD, 32'h0, 0, 1'b1, 1'b0);
    run_op(MAT_MUL, 32'h0, 4, 1'b1, 1'b0);
    run_op(MAT_SCAL_INV, 32'h40000000, 2, 1'b1, 1'b0);
    run_op(MAT_SCAL_DIV, 32'h40800000, 6, 1'b1, 1'b1);

    fu_lat = 7;
    clear_logs();
    tick();
    op_code = MAT_SCAL_ADD; scalar = 32'h40000000; n_words = AW'(3); start = 1'b1;
    tick();
    start = 1'b0; s = cyc;
    repeat (4) tick();
    check("pre_reset_busy", {busy, memA_read, memRes_write}, 3'b100);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    tick();
    reset = 1'b0;
    clear_logs();
    repeat (15) tick();
    check("post_reset_writes", n_wr, 0);
    check("post_reset_done", n_done, 0);
    run_op(MAT_SCAL_ADD, r2fp(real'($urandom_range(1, 100))), 4, 1'b1, 1'b0);

    for (int r = 0; r < 5; r++) begin
      op = sup_ops[$urandom_range(0, 3)];
      sc = (op == MAT_SCAL_ADD) ? r2fp(real'($urandom_range(1, 500))) : pow2_sc[$urandom_range(0, 2)];
      run_op(op, sc, $urandom_range(1, 12), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
